mmio_fifo_ctrl: RTL and testbench

MMIO-side controller for the AFU's 64-bit host-visible FIFO. It decodes CCI-P MMIO writes and reads in a small register window and turns them into FIFO push, pop, peek, status and flush operations. It keeps occupancy and sticky error state, and returns one registered read response per read request. The AFU top instantiates it between the Rx c0 MMIO decode and the Tx c2 response mux. The top forwards the response only when `rsp_hit` is high; otherwise it uses its own DFH/user-register response.

---
 rtl/mmio_fifo_pkg.sv | 24 ++
 rtl/mmio_fifo_ram.sv | 25 ++
 rtl/mmio_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_mmio_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_fifo_pkg.sv
// Shared register map for the MMIO FIFO controller.
// Offsets are relative to BASE_ADDR in 4-byte MMIO word units.
// Status read bits and STATUS write command bits live here too.
package mmio_fifo_pkg;

  // Register offsets within the 8-word window
  localparam logic [2:0] OFF_PUSH   = 3'd0;
  localparam logic [2:0] OFF_POP    = 3'd2;
  localparam logic [2:0] OFF_PEEK   = 3'd4;
  localparam logic [2:0] OFF_STATUS = 3'd6;

  // STATUS read bit positions
  localparam int ST_EMPTY  = 0;
  localparam int ST_FULL   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_UDF    = 3;
  localparam int ST_PERR   = 4;
  localparam int ST_CNT_LO = 8;

  // STATUS write command bit positions
  localparam int CMD_CLR   = 0;
  localparam int CMD_FLUSH = 1;

endpackage

// File: rtl/mmio_fifo_ram.sv
// DEPTH x 64 storage for the MMIO FIFO.
// Write is captured on clk; read is combinational at the head pointer.
// No flow control; contents are never reset.
module mmio_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [63:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [63:0]   rd_data
);

  logic [63:0] mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// MMIO register window driving a 64-bit FIFO: push/pop/peek/status/flush.
// Read response is registered: exactly one cycle after the request.
// No backpressure: full pushes are dropped (ovf), empty pops return 0 (udf).
module mmio_fifo_ctrl
  import mmio_fifo_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [8:0]  mmio_tid,
  input  logic [63:0] mmio_wr_data,
  output logic        rsp_valid,
  output logic        rsp_hit,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic [7:0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf, udf, perr;
  logic [63:0]   head;
  logic [63:0]   rd_word;

  // BASE_ADDR is 8-aligned, so the window is one 8-word block; odd words are holes
  wire       win     = (mmio_addr[15:3] == BASE_ADDR[15:3]) && !mmio_addr[0];
  wire [2:0] off     = mmio_addr[2:0];
  wire       empty   = (cnt == '0);
  wire       full    = (cnt == CW'(DEPTH));
  wire       collide = mmio_wr_valid && mmio_rd_valid;

  // A colliding write is dropped; the read still goes ahead
  wire wr_ok    = mmio_wr_valid && !mmio_rd_valid && win;
  wire do_push  = wr_ok && (off == OFF_PUSH) && !full;
  wire push_ovf = wr_ok && (off == OFF_PUSH) && full;
  wire st_wr    = wr_ok && (off == OFF_STATUS);
  wire clr      = st_wr && mmio_wr_data[CMD_CLR];
  wire flush    = st_wr && mmio_wr_data[CMD_FLUSH];
  wire rd_hit   = mmio_rd_valid && win;
  wire do_pop   = rd_hit && (off == OFF_POP) && !empty;
  wire pop_udf  = rd_hit && (off == OFF_POP) && empty;

  mmio_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (do_push),
    .wr_addr (wr_ptr),
    .wr_data (mmio_wr_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  // Read mux; STATUS already shows perr for a read that collides with a write
  always_comb begin
    rd_word = '0;
    case (off)
      OFF_POP, OFF_PEEK: rd_word = empty ? 64'd0 : head;
      OFF_STATUS: begin
        rd_word[ST_EMPTY]             = empty;
        rd_word[ST_FULL]              = full;
        rd_word[ST_OVF]               = ovf;
        rd_word[ST_UDF]               = udf;
        rd_word[ST_PERR]              = perr | collide;
        rd_word[ST_CNT_LO +: 8]       = 8'(cnt);
      end
      default: rd_word = '0;
    endcase
  end

  // Pointers and occupancy; push and pop never coincide since collisions drop the write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + AW'(1);
      cnt    <= cnt + CW'(1);
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt - CW'(1);
    end
  end

  // Sticky error flags, cleared only by a STATUS write with the clear bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      udf  <= 1'b0;
      perr <= 1'b0;
    end else begin
      ovf  <= (ovf  && !clr) || push_ovf;
      udf  <= (udf  && !clr) || pop_udf;
      perr <= (perr && !clr) || collide;
    end
  end

  // One registered response per read request; misses echo the TID with zero data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_tid   <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= mmio_rd_valid;
      rsp_hit   <= rd_hit;
      if (mmio_rd_valid) begin
        rsp_tid  <= mmio_tid;
        rsp_data <= rd_hit ? rd_word : 64'd0;
      end
    end
  end

  assign count = 8'(cnt);

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// Self-checking bench for mmio_fifo_ctrl.
// Reference model: a queue plus three flags, updated per MMIO request.
// Directed test-plan sequences followed by randomized request mix.
module tb_mmio_fifo_ctrl;

  localparam int          DEPTH = 16;
  localparam logic [15:0] BASE  = 16'h0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmio_wr_valid, mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wr_data;
  logic        rsp_valid, rsp_hit;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic [7:0]  count;

  mmio_fifo_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rst           (rst),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_addr     (mmio_addr),
    .mmio_tid      (mmio_tid),
    .mmio_wr_data  (mmio_wr_data),
    .rsp_valid     (rsp_valid),
    .rsp_hit       (rsp_hit),
    .rsp_tid       (rsp_tid),
    .rsp_data      (rsp_data),
    .count         (count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [63:0] mq[$];
  bit m_ovf, m_udf, m_perr;

  logic [63:0] last_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_status();
    int s;
    s = (mq.size() == 0 ? 1 : 0) + (mq.size() == DEPTH ? 2 : 0)
      + (m_ovf ? 4 : 0) + (m_udf ? 8 : 0) + (m_perr ? 16 : 0)
      + mq.size() * 256;
    return 64'(s);
  endfunction

  // Apply one request to the model; returns expected hit and data for a read
  task automatic model_step(input bit wr, input bit rd, input logic [15:0] addr,
                            input logic [63:0] wd, output bit e_hit, output logic [63:0] e_data);
    int a, o;
    bit inwin;
    a = int'(addr);
    o = a - int'(BASE);
    inwin = (o >= 0) && (o < 8) && (o % 2 == 0);
    e_hit = rd && inwin;
    e_data = 64'd0;
    if (wr && rd) m_perr = 1;
    if (rd && inwin) begin
      case (o)
        2: if (mq.size() > 0) e_data = mq.pop_front(); else m_udf = 1;
        4: if (mq.size() > 0) e_data = mq[0];
        6: e_data = model_status();
        default: e_data = 64'd0;
      endcase
    end
    if (wr && !rd && inwin) begin
      if (o == 0) begin
        if (mq.size() < DEPTH) mq.push_back(wd); else m_ovf = 1;
      end else if (o == 6) begin
        if (wd[0]) begin m_ovf = 0; m_udf = 0; m_perr = 0; end
        if (wd[1]) mq.delete();
      end
    end
  endtask

  task automatic issue(input bit wr, input bit rd, input logic [15:0] addr,
                       input logic [8:0] tid, input logic [63:0] wd);
    bit e_hit;
    logic [63:0] e_data;
    @(negedge clk);
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = addr;
    mmio_tid      = tid;
    mmio_wr_data  = wd;
    model_step(wr, rd, addr, wd, e_hit, e_data);
    @(posedge clk);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(rd));
    if (rd) begin
      check("rsp_hit", 64'(rsp_hit), 64'(e_hit));
      check("rsp_tid", 64'(rsp_tid), 64'(tid));
      check("rsp_data", rsp_data, e_data);
    end
    check("count", 64'(count), 64'(mq.size()));
    last_data = rsp_data;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] va, vb, vc;
    rst = 1'b1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    mmio_addr = '0;
    mmio_tid = '0;
    mmio_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_hit", 64'(rsp_hit), 64'd0);
    check("reset_tid", 64'(rsp_tid), 64'd0);
    check("reset_data", rsp_data, 64'd0);
    check("reset_count", 64'(count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Status after reset
    issue(0, 1, BASE + 16'd6, 9'h1A5, 64'd0);
    check("t1_status", last_data, 64'h1);

    // Push A,B,C; peek; pop x3
    va = rnd64(); vb = rnd64(); vc = rnd64();
    issue(1, 0, BASE, 9'd0, va);
    issue(1, 0, BASE, 9'd0, vb);
    issue(1, 0, BASE, 9'd0, vc);
    issue(0, 1, BASE + 16'd4, 9'd1, 64'd0);
    check("t2_peek", last_data, va);
    issue(0, 1, BASE + 16'd2, 9'd2, 64'd0);
    check("t2_pop_a", last_data, va);
    issue(0, 1, BASE + 16'd2, 9'd3, 64'd0);
    issue(0, 1, BASE + 16'd2, 9'd4, 64'd0);
    check("t2_pop_c", last_data, vc);
    issue(0, 1, BASE + 16'd6, 9'd5, 64'd0);
    check("t2_status", last_data, 64'h1);

    // Overflow, drain with wrap, underflow
    for (int i = 0; i <= DEPTH; i++) issue(1, 0, BASE, 9'd0, 64'(i) + 64'h100);
    issue(0, 1, BASE + 16'd6, 9'd6, 64'd0);
    check("t3_full_status", last_data, (64'(DEPTH) << 8) | 64'h6);
    for (int i = 0; i < DEPTH; i++) issue(0, 1, BASE + 16'd2, 9'(i), 64'd0);
    check("t3_last_pop", last_data, 64'(DEPTH - 1) + 64'h100);
    issue(0, 1, BASE + 16'd2, 9'd7, 64'd0);
    check("t3_udf_pop", last_data, 64'd0);

    // Clear + flush with 5 queued
    for (int i = 0; i < 5; i++) issue(1, 0, BASE, 9'd0, rnd64());
    issue(1, 0, BASE + 16'd6, 9'd0, 64'h3);
    issue(0, 1, BASE + 16'd6, 9'd8, 64'd0);
    check("t4_status", last_data, 64'h1);

    // Collision, then out-of-window read
    issue(1, 0, BASE, 9'd0, rnd64());
    issue(1, 1, BASE + 16'd6, 9'd9, rnd64());
    check("t5_perr", last_data, 64'h110);
    issue(0, 1, BASE + 16'd8, 9'h1FF, 64'd0);
    issue(0, 1, BASE + 16'd3, 9'h0AA, 64'd0);
    issue(1, 0, BASE + 16'd6, 9'd0, 64'h1);

    // Randomized mix
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [15:0] a;
      r = $urandom_range(0, 15);
      case (r)
        0, 1, 2, 3, 4, 5: issue(1, 0, BASE, 9'($urandom()), rnd64());
        6, 7: issue(0, 1, BASE + 16'd2, 9'($urandom()), 64'd0);
        8: issue(0, 1, BASE + 16'd4, 9'($urandom()), 64'd0);
        9, 10: issue(0, 1, BASE + 16'd6, 9'($urandom()), 64'd0);
        11: issue(1, 0, BASE + 16'd6, 9'd0, 64'($urandom_range(0, 3)));
        12: issue(1, 1, BASE + 16'(2 * $urandom_range(0, 3)), 9'($urandom()), rnd64());
        default: begin
          case ($urandom_range(0, 4))
            0: a = BASE + 16'd1;
            1: a = BASE + 16'd5;
            2: a = BASE + 16'd8;
            3: a = BASE - 16'd2;
            default: a = 16'($urandom());
          endcase
          issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 9'($urandom()), rnd64());
        end
      endcase
    end

    // Reset while a POP response is pending
    issue(1, 0, BASE, 9'd0, rnd64());
    @(negedge clk);
    mmio_rd_valid = 1'b1;
    mmio_addr = BASE + 16'd2;
    mmio_tid = 9'h055;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_hit", 64'(rsp_hit), 64'd0);
    check("rst_tid", 64'(rsp_tid), 64'd0);
    check("rst_data", rsp_data, 64'd0);
    check("rst_count", 64'(count), 64'd0);
    mmio_rd_valid = 1'b0;
    mq.delete();
    m_ovf = 0; m_udf = 0; m_perr = 0;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 1, BASE + 16'd6, 9'd10, 64'd0);
    check("post_rst_status", last_data, 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
